// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the execution-result writeback arbiter.
package writeback_arbiter_pkg;

    localparam int unsigned NUM_SRC    = 5;
    localparam int unsigned WB_PORTS   = 2;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned ROB_ID_W   = 6;
    localparam int unsigned PHYS_W     = 7;
    localparam int unsigned SRC_W      = 3;
    localparam int unsigned WB_COUNT_W = 32;

    localparam logic [SRC_W-1:0] SRC_ALU0    = 3'd0;
    localparam logic [SRC_W-1:0] SRC_ALU1    = 3'd1;
    localparam logic [SRC_W-1:0] SRC_COMPLEX = 3'd2;
    localparam logic [SRC_W-1:0] SRC_MULDIV  = 3'd3;
    localparam logic [SRC_W-1:0] SRC_LSU     = 3'd4;

    typedef struct packed {
        logic [XLEN-1:0]     result;
        logic [ROB_ID_W-1:0] rob_id;
        logic [PHYS_W-1:0]   phys_dest;
        logic                exception;
    } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Source-result and writeback-port bundle; master drives results, slave is the arbiter.
interface writeback_arbiter_if #(
    parameter int unsigned NUM_SRC = writeback_arbiter_pkg::NUM_SRC
);
    import writeback_arbiter_pkg::*;

    logic                           flush_i;
    logic [NUM_SRC-1:0]             src_valid_i;
    logic [NUM_SRC*XLEN-1:0]        src_result_i;
    logic [NUM_SRC*ROB_ID_W-1:0]    src_rob_id_i;
    logic [NUM_SRC*PHYS_W-1:0]      src_phys_dest_i;
    logic [NUM_SRC-1:0]             src_exception_i;
    logic [NUM_SRC-1:0]             src_stall_o;
    logic [NUM_SRC-1:0]             src_overflow_o;
    logic [WB_PORTS-1:0]            wb_valid_o;
    logic [WB_PORTS*XLEN-1:0]       wb_data_o;
    logic [WB_PORTS*ROB_ID_W-1:0]   wb_rob_id_o;
    logic [WB_PORTS*PHYS_W-1:0]     wb_phys_dest_o;
    logic [WB_PORTS-1:0]            wb_exception_o;
    logic [WB_PORTS*SRC_W-1:0]      wb_src_o;
    logic [WB_COUNT_W-1:0]          wb_count_o;

    modport master (
        output flush_i, src_valid_i, src_result_i, src_rob_id_i, src_phys_dest_i,
               src_exception_i,
        input  src_stall_o, src_overflow_o, wb_valid_o, wb_data_o, wb_rob_id_o,
               wb_phys_dest_o, wb_exception_o, wb_src_o, wb_count_o
    );

    modport slave (
        input  flush_i, src_valid_i, src_result_i, src_rob_id_i, src_phys_dest_i,
               src_exception_i,
        output src_stall_o, src_overflow_o, wb_valid_o, wb_data_o, wb_rob_id_o,
               wb_phys_dest_o, wb_exception_o, wb_src_o, wb_count_o
    );

endinterface

// File: rtl/wb_src_fifo.sv
// Per-source result FIFO; a push into a full FIFO is accepted only when the head pops that cycle.
module wb_src_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  wb_entry_t                    din,
    output wb_entry_t                    dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && !flush && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    // Pointer/occupancy state; flush drains the queue without touching storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Collects results from the execution units into per-source FIFOs and drains
// up to two heads per cycle to the ROB/PRF writeback ports in round-robin order.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC    = writeback_arbiter_pkg::NUM_SRC,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    writeback_arbiter_if.slave bus
);

    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

    wb_entry_t               push_entry [NUM_SRC];
    wb_entry_t               head       [NUM_SRC];
    logic [FCNT_W-1:0]       fifo_count [NUM_SRC];
    logic [NUM_SRC-1:0]      fifo_full;
    logic [NUM_SRC-1:0]      fifo_empty;
    logic [NUM_SRC-1:0]      fifo_pop_c;
    logic [NUM_SRC-1:0]      stall_c;
    logic [NUM_SRC-1:0]      drop_c;

    logic [SRC_W-1:0]        rr_ptr;
    logic [SRC_W-1:0]        rr_next_c;
    logic [SRC_W-1:0]        grant0_c;
    logic [SRC_W-1:0]        grant1_c;
    logic                    hit0_c;
    logic                    hit1_c;
    logic [WB_COUNT_W-1:0]   wb_count_q;
    logic [NUM_SRC-1:0]      overflow_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign push_entry[i] = '{
            result:    bus.src_result_i[i*XLEN +: XLEN],
            rob_id:    bus.src_rob_id_i[i*ROB_ID_W +: ROB_ID_W],
            phys_dest: bus.src_phys_dest_i[i*PHYS_W +: PHYS_W],
            exception: bus.src_exception_i[i]
        };

        wb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (bus.flush_i),
            .push  (bus.src_valid_i[i]),
            .pop   (fifo_pop_c[i]),
            .din   (push_entry[i]),
            .dout  (head[i]),
            .count (fifo_count[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i])
        );
    end

    // Round-robin search from rr_ptr: first non-empty source to port 0, second to port 1.
    always_comb begin
        logic [SRC_W-1:0] idx;
        idx      = '0;
        hit0_c   = 1'b0;
        hit1_c   = 1'b0;
        grant0_c = '0;
        grant1_c = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = SRC_W'((32'(rr_ptr) + k) % NUM_SRC);
            if (!bus.flush_i && !fifo_empty[idx]) begin
                if (!hit0_c) begin
                    hit0_c   = 1'b1;
                    grant0_c = idx;
                end else if (!hit1_c) begin
                    hit1_c   = 1'b1;
                    grant1_c = idx;
                end
            end
        end
        rr_next_c = SRC_W'((32'(hit1_c ? grant1_c : grant0_c) + 32'd1) % NUM_SRC);
    end

    always_comb begin
        fifo_pop_c = '0;
        stall_c    = '0;
        drop_c     = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            fifo_pop_c[i] = (hit0_c && grant0_c == SRC_W'(i)) ||
                            (hit1_c && grant1_c == SRC_W'(i));
            stall_c[i]    = (fifo_count[i] == FCNT_W'(FIFO_DEPTH));
            drop_c[i]     = bus.src_valid_i[i] && !bus.flush_i && fifo_full[i] && !fifo_pop_c[i];
        end
    end

    // Writeback ports present the granted heads directly; idle ports read as zero.
    always_comb begin
        wb_entry_t e0;
        wb_entry_t e1;
        e0 = hit0_c ? head[grant0_c] : '0;
        e1 = hit1_c ? head[grant1_c] : '0;
        bus.wb_valid_o     = {hit1_c, hit0_c};
        bus.wb_data_o      = {e1.result, e0.result};
        bus.wb_rob_id_o    = {e1.rob_id, e0.rob_id};
        bus.wb_phys_dest_o = {e1.phys_dest, e0.phys_dest};
        bus.wb_exception_o = {e1.exception, e0.exception};
        bus.wb_src_o       = {grant1_c, grant0_c};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            wb_count_q <= '0;
            overflow_q <= '0;
        end else begin
            if (hit0_c) rr_ptr <= rr_next_c;
            wb_count_q <= wb_count_q + WB_COUNT_W'(hit0_c) + WB_COUNT_W'(hit1_c);
            overflow_q <= overflow_q | drop_c;
        end
    end

    assign bus.src_stall_o    = stall_c;
    assign bus.src_overflow_o = overflow_q;
    assign bus.wb_count_o     = wb_count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with hand-computed expectations.
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    writeback_arbiter_if #(.NUM_SRC(5)) bus ();

    writeback_arbiter #(.NUM_SRC(5), .FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.flush_i         = 1'b0;
        bus.src_valid_i     = '0;
        bus.src_result_i    = '0;
        bus.src_rob_id_i    = '0;
        bus.src_phys_dest_i = '0;
        bus.src_exception_i = '0;
    endtask

    task automatic load(input int i, input logic [31:0] res, input logic [5:0] rob,
                        input logic [6:0] pd, input logic exc);
        bus.src_valid_i[i]            = 1'b1;
        bus.src_result_i[i*32 +: 32]  = res;
        bus.src_rob_id_i[i*6 +: 6]    = rob;
        bus.src_phys_dest_i[i*7 +: 7] = pd;
        bus.src_exception_i[i]        = exc;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        tick();
        tick();
        check_eq("rst_valid", 64'(bus.wb_valid_o), 64'h0);
        check_eq("rst_stall", 64'(bus.src_stall_o), 64'h0);
        check_eq("rst_ovf", 64'(bus.src_overflow_o), 64'h0);
        check_eq("rst_count", 64'(bus.wb_count_o), 64'h0);
        rst = 1'b0;

        // Single result from alu0
        load(0, 32'hDEADBEEF, 6'd5, 7'd9, 1'b0);
        #1;
        check_eq("no_bypass", 64'(bus.wb_valid_o), 64'h0);
        tick();
        idle_inputs();
        check_eq("single_valid", 64'(bus.wb_valid_o), 64'h1);
        check_eq("single_data", 64'(bus.wb_data_o), 64'h0000_0000_DEAD_BEEF);
        check_eq("single_rob", 64'(bus.wb_rob_id_o), 64'd5);
        check_eq("single_pd", 64'(bus.wb_phys_dest_o), 64'd9);
        check_eq("single_src", 64'(bus.wb_src_o), 64'h0);
        tick();
        check_eq("single_drained", 64'(bus.wb_valid_o), 64'h0);
        check_eq("single_count", 64'(bus.wb_count_o), 64'd1);

        // lsu alone with exception; moves rr_ptr back to 0
        load(4, 32'h0000_0044, 6'd44, 7'd100, 1'b1);
        tick();
        idle_inputs();
        check_eq("lsu_valid", 64'(bus.wb_valid_o), 64'h1);
        check_eq("lsu_src", 64'(bus.wb_src_o), 64'h04);
        check_eq("lsu_exc", 64'(bus.wb_exception_o), 64'h1);
        check_eq("lsu_rob", 64'(bus.wb_rob_id_o), 64'd44);
        check_eq("lsu_pd", 64'(bus.wb_phys_dest_o), 64'd100);
        tick();
        check_eq("lsu_count", 64'(bus.wb_count_o), 64'd2);

        // All five sources at once
        for (int i = 0; i < 5; i++) load(i, 32'h1000_0000 + 32'(i), 6'(i), 7'(i), 1'b0);
        tick();
        idle_inputs();
        check_eq("all5_c1_valid", 64'(bus.wb_valid_o), 64'h3);
        check_eq("all5_c1_src", 64'(bus.wb_src_o), 64'h08);
        check_eq("all5_c1_data", 64'(bus.wb_data_o), 64'h1000_0001_1000_0000);
        tick();
        check_eq("all5_c2_valid", 64'(bus.wb_valid_o), 64'h3);
        check_eq("all5_c2_src", 64'(bus.wb_src_o), 64'h1A);
        check_eq("all5_c2_data", 64'(bus.wb_data_o), 64'h1000_0003_1000_0002);
        tick();
        check_eq("all5_c3_valid", 64'(bus.wb_valid_o), 64'h1);
        check_eq("all5_c3_src", 64'(bus.wb_src_o), 64'h04);
        check_eq("all5_c3_data", 64'(bus.wb_data_o), 64'h0000_0000_1000_0004);
        tick();
        check_eq("all5_idle", 64'(bus.wb_valid_o), 64'h0);
        check_eq("all5_count", 64'(bus.wb_count_o), 64'd7);

        // muldiv alone: rr_ptr becomes 4
        load(3, 32'h0000_0033, 6'd3, 7'd3, 1'b0);
        tick();
        idle_inputs();
        check_eq("md_src", 64'(bus.wb_src_o), 64'h03);
        tick();
        check_eq("md_count", 64'(bus.wb_count_o), 64'd8);

        // muldiv fills while others win arbitration; third push is dropped
        for (int i = 0; i < 5; i++) load(i, 32'h2000_0000 + 32'(i), 6'(i), 7'(i), 1'b0);
        tick();
        idle_inputs();
        load(3, 32'h2000_0013, 6'd13, 7'd13, 1'b0);
        check_eq("ovf_p1_src", 64'(bus.wb_src_o), 64'h04);
        check_eq("ovf_p1_data", 64'(bus.wb_data_o), 64'h2000_0000_2000_0004);
        check_eq("ovf_p1_stall", 64'(bus.src_stall_o), 64'h0);
        tick();
        idle_inputs();
        load(3, 32'h2000_0023, 6'd23, 7'd23, 1'b0);
        check_eq("ovf_p2_stall", 64'(bus.src_stall_o), 64'h08);
        check_eq("ovf_p2_src", 64'(bus.wb_src_o), 64'h11);
        check_eq("ovf_p2_data", 64'(bus.wb_data_o), 64'h2000_0002_2000_0001);
        check_eq("ovf_p2_ovf", 64'(bus.src_overflow_o), 64'h0);
        tick();
        idle_inputs();
        check_eq("ovf_p3_ovf", 64'(bus.src_overflow_o), 64'h08);
        check_eq("ovf_p3_stall", 64'(bus.src_stall_o), 64'h08);
        check_eq("ovf_p3_src", 64'(bus.wb_src_o), 64'h03);
        check_eq("ovf_p3_data", 64'(bus.wb_data_o), 64'h0000_0000_2000_0003);
        tick();
        check_eq("ovf_d2_data", 64'(bus.wb_data_o), 64'h0000_0000_2000_0013);
        check_eq("ovf_d2_stall", 64'(bus.src_stall_o), 64'h0);
        tick();
        check_eq("ovf_d3_valid", 64'(bus.wb_valid_o), 64'h0);
        check_eq("ovf_sticky", 64'(bus.src_overflow_o), 64'h08);
        check_eq("ovf_count", 64'(bus.wb_count_o), 64'd14);

        // alu1 full, popped and pushed in the same cycle
        load(0, 32'h3000_0000, 6'd0, 7'd0, 1'b0);
        load(1, 32'h3000_0001, 6'd1, 7'd1, 1'b0);
        load(4, 32'h3000_0004, 6'd4, 7'd4, 1'b0);
        tick();
        idle_inputs();
        load(1, 32'h3000_0011, 6'd11, 7'd11, 1'b0);
        check_eq("full_q1_src", 64'(bus.wb_src_o), 64'h04);
        tick();
        idle_inputs();
        load(1, 32'h3000_0021, 6'd21, 7'd21, 1'b0);
        check_eq("full_q2_stall", 64'(bus.src_stall_o), 64'h02);
        check_eq("full_q2_data", 64'(bus.wb_data_o), 64'h0000_0000_3000_0001);
        tick();
        idle_inputs();
        check_eq("full_q3_stall", 64'(bus.src_stall_o), 64'h02);
        check_eq("full_q3_ovf", 64'(bus.src_overflow_o), 64'h08);
        check_eq("full_q3_data", 64'(bus.wb_data_o), 64'h0000_0000_3000_0011);
        tick();
        check_eq("full_q4_data", 64'(bus.wb_data_o), 64'h0000_0000_3000_0021);
        check_eq("full_q4_stall", 64'(bus.src_stall_o), 64'h0);
        tick();
        check_eq("full_idle", 64'(bus.wb_valid_o), 64'h0);
        check_eq("full_count", 64'(bus.wb_count_o), 64'd19);

        // Flush with three queued sources and pushes on every source
        for (int i = 0; i < 3; i++) load(i, 32'h4000_0000 + 32'(i), 6'(i), 7'(i), 1'b0);
        tick();
        idle_inputs();
        check_eq("pre_flush_src", 64'(bus.wb_src_o), 64'h02);
        bus.flush_i = 1'b1;
        for (int i = 0; i < 5; i++) load(i, 32'h4100_0000 + 32'(i), 6'(i), 7'(i), 1'b0);
        #1;
        check_eq("flush_valid", 64'(bus.wb_valid_o), 64'h0);
        check_eq("flush_data", 64'(bus.wb_data_o), 64'h0);
        tick();
        idle_inputs();
        check_eq("post_flush_valid", 64'(bus.wb_valid_o), 64'h0);
        check_eq("post_flush_stall", 64'(bus.src_stall_o), 64'h0);
        check_eq("post_flush_count", 64'(bus.wb_count_o), 64'd19);
        check_eq("post_flush_ovf", 64'(bus.src_overflow_o), 64'h08);
        tick();
        check_eq("post_flush_idle", 64'(bus.wb_valid_o), 64'h0);

        // rr_ptr kept at 2 across the flush
        for (int i = 0; i < 5; i++) load(i, 32'h5000_0000 + 32'(i), 6'(i), 7'(i), 1'b0);
        tick();
        idle_inputs();
        check_eq("rr_c1_src", 64'(bus.wb_src_o), 64'h1A);
        tick();
        check_eq("rr_c2_src", 64'(bus.wb_src_o), 64'h04);
        tick();
        check_eq("rr_c3_src", 64'(bus.wb_src_o), 64'h01);
        tick();
        check_eq("rr_count", 64'(bus.wb_count_o), 64'd24);

        // Counter wrap
        force dut.wb_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.wb_count_q;
        check_eq("wrap_preset", 64'(bus.wb_count_o), 64'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) load(i, 32'h7000_0000 + 32'(i), 6'(i), 7'(i), 1'b0);
        tick();
        idle_inputs();
        check_eq("wrap_grant2", 64'(bus.wb_valid_o), 64'h3);
        tick();
        check_eq("wrap_zero", 64'(bus.wb_count_o), 64'h0);
        check_eq("wrap_grant1", 64'(bus.wb_valid_o), 64'h1);
        tick();
        check_eq("wrap_one", 64'(bus.wb_count_o), 64'h1);

        // Asynchronous reset with queued results
        load(0, 32'h6000_0000, 6'd0, 7'd0, 1'b0);
        load(1, 32'h6000_0001, 6'd1, 7'd1, 1'b0);
        tick();
        idle_inputs();
        check_eq("pre_rst_valid", 64'(bus.wb_valid_o), 64'h3);
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_rst_valid", 64'(bus.wb_valid_o), 64'h0);
        check_eq("async_rst_count", 64'(bus.wb_count_o), 64'h0);
        check_eq("async_rst_ovf", 64'(bus.src_overflow_o), 64'h0);
        tick();
        rst = 1'b0;
        load(2, 32'h6000_0002, 6'd2, 7'd2, 1'b0);
        #1;
        check_eq("post_rst_nobypass", 64'(bus.wb_valid_o), 64'h0);
        tick();
        idle_inputs();
        check_eq("post_rst_valid", 64'(bus.wb_valid_o), 64'h1);
        check_eq("post_rst_src", 64'(bus.wb_src_o), 64'h02);
        check_eq("post_rst_data", 64'(bus.wb_data_o), 64'h0000_0000_6000_0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 5, number of 32-bit result sources; index 0=alu0, 1=alu1, 2=complex, 3=muldiv, 4=lsu.
REQ-002 Parameter FIFO_DEPTH, default 2, entries per source FIFO.
REQ-003 Parameter WB_PORTS, fixed 2, writeback ports to ROB/PRF.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 flush_i  in  1  pipeline flush, synchronous.
REQ-007 src_valid_i  in  NUM_SRC  per-source result valid pulse.
REQ-008 src_result_i  in  NUM_SRC*32  per-source result, source i at [32i+31:32i].
REQ-009 src_rob_id_i  in  NUM_SRC*6  per-source ROB id.
REQ-010 src_phys_dest_i  in  NUM_SRC*7  per-source physical destination.
REQ-011 src_exception_i  in  NUM_SRC  per-source exception flag.
REQ-012 src_stall_o  out  NUM_SRC  stop-issue to source i.
REQ-013 src_overflow_o  out  NUM_SRC  sticky dropped-result error.
REQ-014 wb_valid_o  out  2  writeback port valid.
REQ-015 wb_data_o  out  2*32  writeback data.
REQ-016 wb_rob_id_o  out  2*6  writeback ROB id.
REQ-017 wb_phys_dest_o  out  2*7  writeback physical destination.
REQ-018 wb_exception_o  out  2  writeback exception.
REQ-019 wb_src_o  out  2*3  granted source index per port.
REQ-020 wb_count_o  out  32  total writebacks performed.

Function
REQ-021 Each source SHALL own a FIFO_DEPTH-entry FIFO of {result, rob_id, phys_dest, exception}; src_valid_i[i] pushes at the clock edge.
REQ-022 Writeback ports SHALL be driven combinationally from FIFO heads; minimum latency src_valid_i to wb_valid_o is 1 cycle; no same-cycle bypass.
REQ-023 Each cycle, up to 2 non-empty FIFOs SHALL be granted by round-robin search starting at rr_ptr; first hit to port 0, second to port 1; each FIFO at most one grant per cycle.
REQ-024 Granted heads SHALL pop at the clock edge; ROB always accepts (no wb backpressure).
REQ-025 rr_ptr SHALL advance to (last granted index + 1) mod NUM_SRC; unchanged when no grant.
REQ-026 Only one FIFO non-empty: port 0 valid, port 1 invalid (wb_valid_o=2'b01); port 1 never valid while port 0 invalid.
REQ-027 src_stall_o[i] SHALL equal (count[i] == FIFO_DEPTH).
REQ-028 Push and pop on a full FIFO in the same cycle SHALL both occur; count unchanged, no overflow.
REQ-029 Push on a full FIFO without pop SHALL drop the new result and set src_overflow_o[i]; cleared only by reset.
REQ-030 flush_i SHALL force wb_valid_o=0 that cycle, empty all FIFOs, discard same-cycle pushes; rr_ptr, wb_count_o, overflow flags unchanged.
REQ-031 wb_count_o SHALL increase by popcount(wb_valid_o) each cycle, wrapping modulo 2^32.
REQ-032 Invalid ports SHALL drive wb_data_o, wb_rob_id_o, wb_phys_dest_o, wb_exception_o, wb_src_o as zero.

Reset
REQ-033 Reset SHALL asynchronously clear all FIFO pointers and counts, rr_ptr=0, wb_count_o=0, src_overflow_o=0; hence wb_valid_o=0, src_stall_o=0.
REQ-034 Reset asserted mid-operation SHALL discard all queued results; first push after deassertion appears 1 cycle later.
REQ-035 FIFO data storage SHALL NOT require reset.

Structure
REQ-036 Shared package SHALL hold NUM_SRC, WB_PORTS, ROB_ID_W=6, PHYS_W=7, XLEN=32, source index constants, and the writeback entry typedef.
REQ-037 One sub-module wb_src_fifo (parameterised depth, push/pop/count/full/empty), instantiated NUM_SRC times.

Verification
REQ-038 Reset, then src_valid_i=5'b00001 with result 32'hDEADBEEF, rob 6'd5, pd 7'd9 -> next cycle wb_valid_o=2'b01, wb_data_o[31:0]=DEADBEEF, wb_src_o[2:0]=0.
REQ-039 All 5 sources push once in the same cycle, rr_ptr=0 -> grants (0,1), then (2,3), then (4,-); wb_count_o=5 after third cycle.
REQ-040 Source 3 pushes 3 consecutive cycles while sources 0,1,2 continuously hold entries -> src_stall_o[3]=1 at count 2; third push dropped, src_overflow_o[3]=1 persists until reset.
REQ-041 Source 1 FIFO full, granted and pushed same cycle -> count stays 2, src_overflow_o[1]=0.
REQ-042 Three FIFOs hold entries, flush_i=1 with src_valid_i=5'b11111 -> wb_valid_o=0 that cycle and the next; all FIFOs empty, wb_count_o unchanged.
REQ-043 wb_count_o preset near 32'hFFFFFFFF via 2-port writebacks -> wraps to 32'h00000000/00000001 correctly.
